// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-granularity main_mem port between
// an I-cache (client 0) and a D-cache (client 1). Ownership is held until
// the memory grant, followed by one idle gap cycle. Each client keeps its
// own captured read line.
module mem_port_arbiter #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 9,
  localparam int unsigned LINE_SIZE    = 2 ** LINE_ADDR_LEN,
  localparam int unsigned LINE_W       = 32 * LINE_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c0_rd_req,
  input  logic                c0_wr_req,
  input  logic [ADDR_LEN-1:0] c0_addr,
  input  logic [LINE_W-1:0]   c0_wr_line,
  output logic [LINE_W-1:0]   c0_rd_line,
  output logic                c0_gnt,
  input  logic                c1_rd_req,
  input  logic                c1_wr_req,
  input  logic [ADDR_LEN-1:0] c1_addr,
  input  logic [LINE_W-1:0]   c1_wr_line,
  output logic [LINE_W-1:0]   c1_rd_line,
  output logic                c1_gnt,
  output logic                mem_rd_req,
  output logic                mem_wr_req,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [LINE_W-1:0]   mem_wr_line,
  input  logic [LINE_W-1:0]   mem_rd_line,
  input  logic                mem_gnt,
  output logic                busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_served;
  logic       last_served_nxt;
  logic       c0_req;
  logic       c1_req;

  assign c0_req = c0_rd_req | c0_wr_req;
  assign c1_req = c1_rd_req | c1_wr_req;
  assign busy   = (state != IDLE);

  // State and round-robin history; last_served=1 lets client 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
    end
  end

  // Next-state, memory-port mux and completion pulses, all decoded from state.
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    c0_gnt          = 1'b0;
    c1_gnt          = 1'b0;
    mem_rd_req      = 1'b0;
    mem_wr_req      = 1'b0;
    mem_addr        = '0;
    mem_wr_line     = '0;
    case (state)
      IDLE: begin
        if (c0_req && c1_req) begin
          state_nxt = last_served ? OWN0 : OWN1;
        end else if (c0_req) begin
          state_nxt = OWN0;
        end else if (c1_req) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        // A simultaneous read+write request is treated as a read.
        mem_rd_req  = c0_rd_req;
        mem_wr_req  = c0_wr_req & ~c0_rd_req;
        mem_addr    = c0_addr;
        mem_wr_line = c0_wr_line;
        if (!c0_req) begin
          state_nxt = GAP;
        end else if (mem_gnt) begin
          c0_gnt          = 1'b1;
          last_served_nxt = 1'b0;
          state_nxt       = GAP;
        end
      end
      OWN1: begin
        mem_rd_req  = c1_rd_req;
        mem_wr_req  = c1_wr_req & ~c1_rd_req;
        mem_addr    = c1_addr;
        mem_wr_line = c1_wr_line;
        if (!c1_req) begin
          state_nxt = GAP;
        end else if (mem_gnt) begin
          c1_gnt          = 1'b1;
          last_served_nxt = 1'b1;
          state_nxt       = GAP;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Per-client read-line capture on a completed read; writes leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_rd_line <= '0;
      c1_rd_line <= '0;
    end else begin
      if (c0_gnt && c0_rd_req) begin
        c0_rd_line <= mem_rd_line;
      end
      if (c1_gnt && c1_rd_req) begin
        c1_rd_line <= mem_rd_line;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// two-client traffic checked against a cycle-level behavioural model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned LW = 256;

  logic          clk;
  logic          rst;
  logic          c0_rd_req, c0_wr_req, c1_rd_req, c1_wr_req;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [LW-1:0] c0_wr_line, c1_wr_line, c0_rd_line, c1_rd_line;
  logic          c0_gnt, c1_gnt;
  logic          mem_rd_req, mem_wr_req, mem_gnt, busy;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wr_line, mem_rd_line;

  int total;
  int bad;

  // Model / client state for the randomized phase.
  bit            pend[2];
  bit            prd[2];
  bit            pwr[2];
  logic [AW-1:0] paddr[2];
  logic [LW-1:0] pline[2];
  logic [LW-1:0] exp_rd[2];
  bit            gseen[2];
  int            m_own;
  int            m_lat;
  int            m_last;
  bit            m_gap;
  int            order[$];

  mem_port_arbiter #(.LINE_ADDR_LEN(3), .ADDR_LEN(AW)) dut (
    .clk(clk), .rst(rst),
    .c0_rd_req(c0_rd_req), .c0_wr_req(c0_wr_req), .c0_addr(c0_addr),
    .c0_wr_line(c0_wr_line), .c0_rd_line(c0_rd_line), .c0_gnt(c0_gnt),
    .c1_rd_req(c1_rd_req), .c1_wr_req(c1_wr_req), .c1_addr(c1_addr),
    .c1_wr_line(c1_wr_line), .c1_rd_line(c1_rd_line), .c1_gnt(c1_gnt),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic drive_clients();
    c0_rd_req  = pend[0] & prd[0];
    c0_wr_req  = pend[0] & pwr[0];
    c0_addr    = paddr[0];
    c0_wr_line = pline[0];
    c1_rd_req  = pend[1] & prd[1];
    c1_wr_req  = pend[1] & pwr[1];
    c1_addr    = paddr[1];
    c1_wr_line = pline[1];
  endtask

  task automatic model_init();
    for (int c = 0; c < 2; c++) begin
      pend[c]   = 1'b0;
      prd[c]    = 1'b0;
      pwr[c]    = 1'b0;
      paddr[c]  = '0;
      pline[c]  = '0;
      exp_rd[c] = '0;
      gseen[c]  = 1'b0;
    end
    m_own  = -1;
    m_lat  = 0;
    m_last = 1;
    m_gap  = 1'b0;
  endtask

  // One clock of randomized traffic: drive, respond as main_mem, check, advance model.
  // mode 1 keeps both clients requesting back-to-back.
  task automatic cycle(input int mode);
    int            k;
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_line;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      if (gseen[c]) begin
        pend[c]  = 1'b0;
        gseen[c] = 1'b0;
      end
      if (!pend[c] && (mode == 1 || $urandom_range(0, 3) == 0)) begin
        k        = int'($urandom_range(0, 7));
        pend[c]  = 1'b1;
        prd[c]   = (k <= 4);
        pwr[c]   = (k == 0) || (k >= 5);
        paddr[c] = AW'($urandom);
        pline[c] = rand_line();
      end
    end
    drive_clients();
    if (m_own >= 0 && m_lat == 0) begin
      mem_gnt     = 1'b1;
      mem_rd_line = rand_line();
    end else if (m_own < 0 && $urandom_range(0, 5) == 0) begin
      mem_gnt     = 1'b1;
      mem_rd_line = rand_line();
    end else begin
      mem_gnt = 1'b0;
    end
    #1;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_line = '0;
    if (m_own >= 0) begin
      e_rd   = prd[m_own];
      e_wr   = pwr[m_own] && !prd[m_own];
      e_addr = paddr[m_own];
      e_line = pline[m_own];
    end
    chk("r_mem_rd_req", LW'(mem_rd_req), LW'(e_rd));
    chk("r_mem_wr_req", LW'(mem_wr_req), LW'(e_wr));
    chk("r_mem_addr", LW'(mem_addr), LW'(e_addr));
    chk("r_mem_wr_line", mem_wr_line, e_line);
    chk("r_busy", LW'(busy), LW'((m_own >= 0) || m_gap));
    chk("r_c0_gnt", LW'(c0_gnt), LW'(m_own == 0 && m_lat == 0));
    chk("r_c1_gnt", LW'(c1_gnt), LW'(m_own == 1 && m_lat == 0));
    chk("r_c0_rd_line", c0_rd_line, exp_rd[0]);
    chk("r_c1_rd_line", c1_rd_line, exp_rd[1]);
    if (c0_gnt) order.push_back(0);
    if (c1_gnt) order.push_back(1);
    if (m_own >= 0) begin
      if (m_lat == 0) begin
        gseen[m_own] = 1'b1;
        if (prd[m_own]) exp_rd[m_own] = mem_rd_line;
        m_last = m_own;
        m_own  = -1;
        m_gap  = 1'b1;
      end else begin
        m_lat--;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (pend[0] || pend[1]) begin
      if (pend[0] && pend[1]) m_own = (m_last == 0) ? 1 : 0;
      else                    m_own = pend[0] ? 0 : 1;
      m_lat = int'($urandom_range(0, 3));
    end
  endtask

  initial begin
    logic [LW-1:0] seq_line, dead_line, junk;
    int n;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 8; i++) begin
      seq_line[32*i +: 32]  = 32'(i);
      dead_line[32*i +: 32] = 32'hDEAD_0000 + 32'(i);
    end
    rst = 1'b1;
    c0_rd_req = 0; c0_wr_req = 0; c0_addr = '0; c0_wr_line = '0;
    c1_rd_req = 0; c1_wr_req = 0; c1_addr = '0; c1_wr_line = '0;
    mem_gnt = 0; mem_rd_line = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", LW'(busy), '0);
    chk("rst_mem_rd_req", LW'(mem_rd_req), '0);
    chk("rst_mem_wr_req", LW'(mem_wr_req), '0);
    chk("rst_c0_rd_line", c0_rd_line, '0);
    chk("rst_c1_rd_line", c1_rd_line, '0);
    @(negedge clk) rst = 1'b0;

    // Single client 0 read with a multi-cycle memory latency.
    @(posedge clk); #1;
    c0_rd_req = 1'b1; c0_addr = 9'h005;
    #1;
    chk("t1_idle_busy", LW'(busy), '0);
    chk("t1_idle_req", LW'(mem_rd_req), '0);
    @(posedge clk); #1;
    chk("t1_mem_rd_req", LW'(mem_rd_req), LW'(1'b1));
    chk("t1_mem_addr", LW'(mem_addr), LW'(9'h005));
    chk("t1_busy", LW'(busy), LW'(1'b1));
    repeat (3) begin
      @(posedge clk); #1;
      chk("t1_hold", LW'(mem_rd_req), LW'(1'b1));
    end
    @(posedge clk); #1;
    mem_gnt = 1'b1; mem_rd_line = seq_line;
    #1;
    chk("t1_c0_gnt", LW'(c0_gnt), LW'(1'b1));
    chk("t1_c1_gnt", LW'(c1_gnt), '0);
    @(posedge clk); #1;
    mem_gnt = 1'b0; c0_rd_req = 1'b0;
    #1;
    chk("t1_gnt_pulse", LW'(c0_gnt), '0);
    chk("t1_c0_rd_line", c0_rd_line, seq_line);
    chk("t1_c1_rd_line", c1_rd_line, '0);
    chk("t1_gap_busy", LW'(busy), LW'(1'b1));
    chk("t1_gap_req", LW'(mem_rd_req), '0);
    @(posedge clk); #1;
    chk("t1_back_idle", LW'(busy), '0);

    // Client 1 write, granted in the first owned cycle.
    c1_wr_req = 1'b1; c1_addr = 9'h1A3; c1_wr_line = dead_line;
    @(posedge clk); #1;
    mem_gnt = 1'b1; mem_rd_line = rand_line();
    #1;
    chk("t4_mem_wr_req", LW'(mem_wr_req), LW'(1'b1));
    chk("t4_mem_rd_req", LW'(mem_rd_req), '0);
    chk("t4_mem_addr", LW'(mem_addr), LW'(9'h1A3));
    chk("t4_mem_wr_line", mem_wr_line, dead_line);
    chk("t4_c1_gnt", LW'(c1_gnt), LW'(1'b1));
    chk("t4_c0_gnt", LW'(c0_gnt), '0);

    // Stray grants during GAP and IDLE must be ignored.
    @(posedge clk); #1;
    c1_wr_req = 1'b0; junk = rand_line(); mem_gnt = 1'b1; mem_rd_line = junk;
    #1;
    chk("t6_gap_c0_gnt", LW'(c0_gnt), '0);
    chk("t6_gap_c1_gnt", LW'(c1_gnt), '0);
    chk("t4_c1_line_kept", c1_rd_line, '0);
    @(posedge clk); #1;
    #1;
    chk("t6_idle_c0_gnt", LW'(c0_gnt), '0);
    chk("t6_idle_c1_gnt", LW'(c1_gnt), '0);
    chk("t6_idle_busy", LW'(busy), '0);
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #1;
    chk("t6_c0_line_kept", c0_rd_line, seq_line);
    chk("t6_c1_line_kept", c1_rd_line, '0);

    // Client drops its request before the grant: one GAP cycle, no completion.
    c0_rd_req = 1'b1; c0_addr = 9'h007;
    @(posedge clk); #1;
    chk("ab_own_req", LW'(mem_rd_req), LW'(1'b1));
    @(posedge clk); #1;
    c0_rd_req = 1'b0;
    #1;
    chk("ab_no_gnt", LW'(c0_gnt), '0);
    @(posedge clk); #1;
    chk("ab_gap_busy", LW'(busy), LW'(1'b1));
    chk("ab_gap_req", LW'(mem_rd_req), '0);
    @(posedge clk); #1;
    chk("ab_idle", LW'(busy), '0);

    // Reset while client 1 owns the port; the following tie goes to client 0.
    c1_rd_req = 1'b1; c1_addr = 9'h055;
    @(posedge clk); #1;
    chk("t5_own1_req", LW'(mem_rd_req), LW'(1'b1));
    chk("t5_own1_addr", LW'(mem_addr), LW'(9'h055));
    #1;
    rst = 1'b1; mem_gnt = 1'b1;
    #1;
    chk("t5_rst_rd_req", LW'(mem_rd_req), '0);
    chk("t5_rst_wr_req", LW'(mem_wr_req), '0);
    chk("t5_rst_busy", LW'(busy), '0);
    chk("t5_rst_c1_gnt", LW'(c1_gnt), '0);
    chk("t5_rst_c0_line", c0_rd_line, '0);
    rst = 1'b0; mem_gnt = 1'b0;
    c0_rd_req = 1'b1; c0_addr = 9'h011;
    @(posedge clk); #1;
    chk("t5_tie_addr", LW'(mem_addr), LW'(9'h011));
    chk("t5_tie_req", LW'(mem_rd_req), LW'(1'b1));

    // Randomized traffic from a fresh reset.
    c0_rd_req = 1'b0; c1_rd_req = 1'b0;
    rst = 1'b1;
    model_init();
    drive_clients();
    @(negedge clk) rst = 1'b0;

    // Both clients requesting back-to-back must alternate, client 0 first.
    order.delete();
    n = 0;
    while (order.size() < 6 && n < 300) begin
      cycle(1);
      n++;
    end
    chk("t3_order_len", LW'(order.size() >= 6), LW'(1'b1));
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      chk("t3_order", LW'(order[i]), LW'(i % 2));
    end

    repeat (500) cycle(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
